slot_alloc: RTL
===============

Name: slot_alloc

Overview:
- Tracks ENTRY tag/slot resources with a busy bitmap.
- Hands out the highest-index free slot each cycle, using the same "highest active bit wins" rule as our priority encoder. Returns slots on a free port.
- Sits directly upstream of pri_enc-based consumers. Used as the tag allocator for reorder/miss buffers.

Parameters:
- ENTRY, 16, number of allocatable slots (≥2).
- ID, $clog2(ENTRY), slot index width.

Ports:
- clk  in  1  clock, rising edge.
- reset_  in  1  asynchronous active-low reset.
- alloc_req  in  1  consumer requests one slot this cycle.
- alloc_ready  out  1  a free slot exists; alloc_id is valid.
- alloc_id  out  ID  slot granted when alloc_req & alloc_ready.
- free_valid  in  1  return slot free_id this cycle.
- free_id  in  ID  slot being returned.
- flush  in  1  synchronous release of all slots.
- busy_vec  out  ENTRY  registered busy bitmap; bit i = 1 means slot i is allocated.
- count  out  ID+1  number of busy slots.
- full  out  1  count == ENTRY.
- empty  out  1  count == 0.
- err  out  1  sticky: illegal free detected.

Behaviour:
- Reset (async, reset_ low):
  - busy_vec = 0, count = 0, err = 0.
  - Therefore full = 0, empty = 1, alloc_ready = 1, alloc_id = ENTRY-1.
- Candidate selection is combinational from registered busy_vec:
  - alloc_id = highest i with busy_vec[i] == 0.
  - alloc_ready = |~busy_vec.
  - When alloc_ready = 0, alloc_id = 0.
- Grant handshake:
  - A grant occurs when alloc_req & alloc_ready in a cycle.
  - At the next rising edge, busy_vec[alloc_id] is set and count increments.
  - alloc_req with alloc_ready = 0 is ignored (no stall state, no queuing). The requester retries.
- Free:
  - free_valid with busy_vec[free_id] = 1 clears that bit at the next edge and decrements count.
  - free_valid with busy_vec[free_id] = 0 (double free) or free_id ≥ ENTRY is ignored. It sets err, which stays set until reset.
- Simultaneous alloc and free, different slots: both apply, count unchanged.
- Simultaneous alloc and free, same slot: cannot occur legally, because the candidate is always a free slot and a legal free targets a busy slot. A free targeting the candidate is therefore an illegal free: err sets and the grant still proceeds.
- Freed slot visibility: a slot freed in cycle N is not a candidate until cycle N+1. A free while full does not make alloc_ready rise in the same cycle.
- flush:
  - Highest priority: at the next edge busy_vec = 0 and count = 0. Any same-cycle alloc/free is discarded.
  - err is not cleared by flush.
- Invariant: count == popcount(busy_vec) at all times.
- full and empty are decoded from the count register (no extra latency).
- Reset asserted mid-operation clears all state immediately, regardless of clk.

Test Plan:
- Reset, hold alloc_req=0 → alloc_ready=1, alloc_id=15, count=0, empty=1, full=0, busy_vec=16'h0000.
- alloc_req=1 for 16 consecutive cycles → granted ids 15,14,…,0 in order. After the 16th edge: busy_vec=16'hFFFF, count=16, full=1, alloc_ready=0. A 17th request produces no change.
- While full, free_valid=1 with free_id=7, alloc_req=1 in the same cycle:
  - No grant that cycle.
  - Next cycle: alloc_ready=1, alloc_id=7, count=15.
  - Grant it → count=16.
- With busy_vec=16'h00F0, one cycle of alloc_req=1 plus free_id=5 → next busy_vec=16'h80D0, count stays 4.
- With busy_vec=16'h0001, free_id=3 (not busy) → err=1, busy_vec and count unchanged. A following legal free of slot 0 → empty=1 and err remains 1.
- Mid-run with count=9:
  - Assert flush → next edge busy_vec=0, count=0, alloc_id=15.
  - Then drop reset_ asynchronously between edges → outputs take reset values before the next clk edge and err=0.

Source files
------------

// File: rtl/slot_alloc.sv
// slot_alloc: tag/slot allocator built on a busy bitmap.
// Each cycle it offers the highest-index free slot. It accepts one grant and
// one free per cycle. A flush releases every slot at once.
//
// Ports:
//   clk, reset_            clock (rising edge), async active-low reset
//   alloc_req              consumer wants one slot this cycle
//   alloc_ready, alloc_id  a free slot exists / which one (0 when none)
//   free_valid, free_id    return a slot
//   flush                  release all slots at the next edge (err kept)
//   busy_vec               registered bitmap, 1 = allocated
//   count, full, empty     occupancy, decoded from the count register
//   err                    sticky illegal-free flag (double free or out of range)
module slot_alloc #(
  parameter int ENTRY = 16,
  parameter int ID    = $clog2(ENTRY)
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             alloc_req,
  output logic             alloc_ready,
  output logic [ID-1:0]    alloc_id,
  input  logic             free_valid,
  input  logic [ID-1:0]    free_id,
  input  logic             flush,
  output logic [ENTRY-1:0] busy_vec,
  output logic [ID:0]      count,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam logic [ID:0] ENTRY_W = (ID+1)'(ENTRY);

  logic             grant;
  logic             free_hit;
  logic             free_ok;
  logic             free_bad;
  logic [ENTRY-1:0] grant_oh;
  logic [ENTRY-1:0] free_oh;

  // Highest free index wins because later loop iterations overwrite earlier ones.
  always_comb begin
    alloc_id = '0;
    for (int i = 0; i < ENTRY; i++)
      if (!busy_vec[i]) alloc_id = ID'(i);
  end

  assign alloc_ready = ~&busy_vec;
  assign grant       = alloc_req & alloc_ready;

  // The slot lookup compares against each legal index.
  // An out-of-range free_id matches no slot and so reads as not busy.
  // This avoids indexing past the end of busy_vec when ENTRY is not a power of two.
  always_comb begin
    free_hit = 1'b0;
    for (int i = 0; i < ENTRY; i++)
      if (free_id == ID'(i)) free_hit = busy_vec[i];
  end

  assign free_ok  = free_valid & free_hit;
  // A free aimed at the current candidate also lands here: the candidate is never busy.
  assign free_bad = free_valid & ~free_hit;

  always_comb begin
    grant_oh = '0;
    free_oh  = '0;
    for (int i = 0; i < ENTRY; i++) begin
      grant_oh[i] = grant   && (alloc_id == ID'(i));
      free_oh[i]  = free_ok && (free_id  == ID'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      busy_vec <= '0;
      count    <= '0;
      err      <= 1'b0;
    end else if (flush) begin
      // Same-cycle alloc/free are discarded entirely, including their error check.
      busy_vec <= '0;
      count    <= '0;
    end else begin
      busy_vec <= (busy_vec | grant_oh) & ~free_oh;
      count    <= count + {{ID{1'b0}}, grant} - {{ID{1'b0}}, free_ok};
      if (free_bad) err <= 1'b1;
    end
  end

  assign full  = (count == ENTRY_W);
  assign empty = (count == '0);

endmodule
